// File: rtl/dram_arb_pkg.sv
// Shared constants for the SPI/dmem data-RAM arbiter: port states, AHB-lite encodings, master ids.
package dram_arb_pkg;

    localparam logic [2:0] P_IDLE  = 3'd0;
    localparam logic [2:0] P_WAIT  = 3'd1;
    localparam logic [2:0] P_RDATA = 3'd2;
    localparam logic [2:0] P_ERR1  = 3'd3;
    localparam logic [2:0] P_ERR2  = 3'd4;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic {
        MST_SPI  = 1'b0,
        MST_DMEM = 1'b1
    } mst_id_e;

endpackage

// File: rtl/dram_arbiter_if.sv
// One AHB-lite master port (address phase, data phase and response) as seen by the RAM arbiter.
interface dram_arbiter_if;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;

    modport master (
        output haddr, htrans, hwrite, hsize, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        input  haddr, htrans, hwrite, hsize, hwdata,
        output hready, hresp, hrdata
    );
endinterface

// File: rtl/ahb_port_ctrl.sv
// Per-master AHB-lite slave: captures the address phase, checks it, and sequences the
// wait/read-data/two-cycle-error data phase around the RAM grant from the top level.
module ahb_port_ctrl
    import dram_arb_pkg::*;
#(
    parameter int          RAM_AW    = 14,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    dram_arbiter_if.slave     bus,
    input  logic              i_grant,
    input  logic [31:0]       i_ram_rdata,
    output logic              o_req,
    output logic              o_write,
    output logic [RAM_AW-1:0] o_addr
);
    localparam logic [31:0] SPAN_MASK = (32'd1 << (RAM_AW + 2)) - 32'd1;

    logic [2:0]        r_state;
    logic [2:0]        w_state_next;
    logic [2:0]        w_after;
    logic              r_write;
    logic [RAM_AW-1:0] r_addr;
    logic              w_hready;
    logic              w_accept;
    logic              w_err;
    logic              w_unused_htrans0;

    assign w_unused_htrans0 = bus.htrans[0];

    assign w_accept = w_hready & bus.htrans[1];
    assign w_err    = (bus.hsize != HSIZE_WORD) |
                      (bus.haddr[1:0] != 2'b00) |
                      ((bus.haddr & ~SPAN_MASK) != BASE_ADDR);
    // State to enter at any edge that ends the current data phase.
    assign w_after  = !w_accept ? P_IDLE : (w_err ? P_ERR1 : P_WAIT);

    // A granted write completes in its first data cycle; everything else waits in P_WAIT.
    assign w_hready = (r_state == P_WAIT) ? (i_grant & r_write) : (r_state != P_ERR1);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            P_IDLE:  w_state_next = w_after;
            P_WAIT:  if (i_grant) w_state_next = r_write ? w_after : P_RDATA;
            P_RDATA: w_state_next = w_after;
            P_ERR1:  w_state_next = P_ERR2;
            P_ERR2:  w_state_next = w_after;
            default: w_state_next = P_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= P_IDLE;
            r_write <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_write <= bus.hwrite;
                r_addr  <= bus.haddr[RAM_AW+1:2];
            end
        end
    end

    assign bus.hready = w_hready;
    assign bus.hresp  = ((r_state == P_ERR1) || (r_state == P_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign bus.hrdata = (r_state == P_RDATA) ? i_ram_rdata : 32'd0;

    assign o_req   = (r_state == P_WAIT);
    assign o_write = r_write;
    assign o_addr  = r_addr;

endmodule

// File: rtl/dram_arbiter.sv
// Shares one single-port data RAM between the SPI loader and the core dmem AHB-lite ports.
// DRAM_ARB_FIXED_PRIO_EN: SPI always wins ties; otherwise ties alternate (round-robin).
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int          RAM_AW    = 14,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    dram_arbiter_if.slave     spi,
    dram_arbiter_if.slave     dmem,
    output logic              ram_cs,
    output logic              ram_rwn,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    logic              w_req_spi, w_req_dmem;
    logic              w_gnt_spi, w_gnt_dmem;
    logic              w_wr_spi, w_wr_dmem;
    logic [RAM_AW-1:0] w_addr_spi, w_addr_dmem;
    logic              w_gnt_write;
    logic [RAM_AW-1:0] w_addr_sel;
    logic [31:0]       w_wdata_sel;
    logic [RAM_AW-1:0] r_addr_hold;
    logic              r_rwn_hold;
    logic [31:0]       r_wdata_hold;

    ahb_port_ctrl #(.RAM_AW(RAM_AW), .BASE_ADDR(BASE_ADDR)) u_spi (
        .clk(clk), .reset(reset), .bus(spi),
        .i_grant(w_gnt_spi), .i_ram_rdata(ram_rdata),
        .o_req(w_req_spi), .o_write(w_wr_spi), .o_addr(w_addr_spi)
    );

    ahb_port_ctrl #(.RAM_AW(RAM_AW), .BASE_ADDR(BASE_ADDR)) u_dmem (
        .clk(clk), .reset(reset), .bus(dmem),
        .i_grant(w_gnt_dmem), .i_ram_rdata(ram_rdata),
        .o_req(w_req_dmem), .o_write(w_wr_dmem), .o_addr(w_addr_dmem)
    );

`ifdef DRAM_ARB_FIXED_PRIO_EN
    assign w_gnt_spi = w_req_spi;
`else
    mst_id_e r_last_grant;

    assign w_gnt_spi = w_req_spi & (!w_req_dmem || (r_last_grant == MST_DMEM));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          r_last_grant <= MST_DMEM;
        else if (w_gnt_spi)  r_last_grant <= MST_SPI;
        else if (w_gnt_dmem) r_last_grant <= MST_DMEM;
    end
`endif
    assign w_gnt_dmem = w_req_dmem & !w_gnt_spi;

    assign w_gnt_write = (w_gnt_spi & w_wr_spi) | (w_gnt_dmem & w_wr_dmem);
    assign w_addr_sel  = w_gnt_spi ? w_addr_spi : w_addr_dmem;
    assign w_wdata_sel = w_gnt_spi ? spi.hwdata : dmem.hwdata;

    // With no grant the RAM bus parks on the last driven address/direction/data.
    assign ram_cs    = w_gnt_spi | w_gnt_dmem;
    assign ram_rwn   = ram_cs ? !w_gnt_write : r_rwn_hold;
    assign ram_addr  = ram_cs ? w_addr_sel : r_addr_hold;
    assign ram_wdata = w_gnt_write ? w_wdata_sel : r_wdata_hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr_hold  <= '0;
            r_rwn_hold   <= 1'b1;
            r_wdata_hold <= 32'd0;
        end else begin
            if (ram_cs) begin
                r_addr_hold <= w_addr_sel;
                r_rwn_hold  <= !w_gnt_write;
            end
            if (w_gnt_write) r_wdata_hold <= w_wdata_sel;
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: vector table, hand-written multi-cycle sequences, and
// concurrent random traffic checked against a per-master word-memory model.
module tb_dram_arbiter;
    import dram_arb_pkg::*;

    localparam int RAM_AW = 14;
    localparam int TMO    = 50;
    localparam int LOGSZ  = 2048;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dram_arbiter_if spi_if();
    dram_arbiter_if dmem_if();

    logic              ram_cs, ram_rwn;
    logic [RAM_AW-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_rdata;

    dram_arbiter #(.RAM_AW(RAM_AW), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .reset(rst_n), .spi(spi_if), .dmem(dmem_if),
        .ram_cs(ram_cs), .ram_rwn(ram_rwn), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Synchronous single-port RAM
    logic [31:0] mem [0:(1<<RAM_AW)-1];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (!ram_rwn) mem[ram_addr] <= ram_wdata;
            else          ram_rdata     <= mem[ram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM access log, sampled mid-cycle
    int          log_n = 0;
    int          log_cyc  [LOGSZ];
    logic [31:0] log_addr [LOGSZ];
    logic        log_rwn  [LOGSZ];
    logic [31:0] log_wd   [LOGSZ];
    always @(negedge clk) begin
        if (ram_cs && log_n < LOGSZ) begin
            log_cyc[log_n]  <= cyc;
            log_addr[log_n] <= 32'(ram_addr);
            log_rwn[log_n]  <= ram_rwn;
            log_wd[log_n]   <= ram_wdata;
            log_n           <= log_n + 1;
        end
    end

    int total = 0;
    int bad   = 0;

    logic [31:0] q_addr [2][4];
    logic        q_wr   [2][4];
    logic [2:0]  q_size [2][4];
    logic [31:0] q_wd   [2][4];
    logic [31:0] res_rd    [2][4];
    logic        res_resp  [2][4];
    logic        res_fresp [2][4];
    int          res_acc   [2][4];
    int          res_done  [2][4];

    logic [31:0] model [2][16];
    bit          valid [2][16];

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        resp;
        int          lat;
        int          ncs;
        logic [31:0] raddr;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic drive_addr(input int m, input logic [31:0] a, input logic [1:0] t,
                              input logic w, input logic [2:0] s);
        if (m == 0) begin
            spi_if.haddr = a; spi_if.htrans = t; spi_if.hwrite = w; spi_if.hsize = s;
        end else begin
            dmem_if.haddr = a; dmem_if.htrans = t; dmem_if.hwrite = w; dmem_if.hsize = s;
        end
    endtask

    task automatic drive_wdata(input int m, input logic [31:0] d);
        if (m == 0) spi_if.hwdata = d;
        else        dmem_if.hwdata = d;
    endtask

    function automatic logic get_ready(input int m);
        return (m == 0) ? spi_if.hready : dmem_if.hready;
    endfunction

    function automatic logic get_resp(input int m);
        return (m == 0) ? spi_if.hresp : dmem_if.hresp;
    endfunction

    function automatic logic [31:0] get_rdata(input int m);
        return (m == 0) ? spi_if.hrdata : dmem_if.hrdata;
    endfunction

    // Issues n pipelined transfers for master m from q_*; called and returns at posedge+1.
    task automatic run_master(input int m, input int n);
        int t;
        drive_addr(m, q_addr[m][0], HTRANS_NONSEQ, q_wr[m][0], q_size[m][0]);
        t = 0;
        while (!get_ready(m) && t < TMO) begin @(posedge clk); #1; t++; end
        if (t >= TMO) begin
            total++; bad++;
            $display("FAIL accept timeout m=%0d", m);
            drive_addr(m, 32'h0, HTRANS_IDLE, 1'b0, HSIZE_WORD);
            return;
        end
        @(posedge clk); #1;
        res_acc[m][0] = cyc;
        for (int k = 0; k < n; k++) begin
            drive_wdata(m, q_wd[m][k]);
            if (k + 1 < n) drive_addr(m, q_addr[m][k+1], HTRANS_NONSEQ, q_wr[m][k+1], q_size[m][k+1]);
            else           drive_addr(m, 32'h0, HTRANS_IDLE, 1'b0, HSIZE_WORD);
            res_fresp[m][k] = get_resp(m);
            t = 0;
            while (!get_ready(m) && t < TMO) begin @(posedge clk); #1; t++; end
            if (t >= TMO) begin
                total++; bad++;
                $display("FAIL data timeout m=%0d k=%0d", m, k);
                drive_addr(m, 32'h0, HTRANS_IDLE, 1'b0, HSIZE_WORD);
                return;
            end
            res_rd[m][k]   = get_rdata(m);
            res_resp[m][k] = get_resp(m);
            @(posedge clk); #1;
            res_done[m][k] = cyc;
            if (k + 1 < n) res_acc[m][k+1] = cyc;
            $display("xfer m=%0d addr=%h wr=%0d size=%0d resp=%0d lat=%0d rdata=%h",
                     m, q_addr[m][k], q_wr[m][k], q_size[m][k], res_resp[m][k],
                     res_done[m][k] - res_acc[m][k], res_rd[m][k]);
        end
    endtask

    task automatic set_q(input int m, input int k, input logic [31:0] a, input logic w,
                         input logic [2:0] s, input logic [31:0] d);
        q_addr[m][k] = a; q_wr[m][k] = w; q_size[m][k] = s; q_wd[m][k] = d;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " spi_hready"},  32'(spi_if.hready), 32'd1);
        chk({tag, " spi_hresp"},   32'(spi_if.hresp), 32'd0);
        chk({tag, " spi_hrdata"},  spi_if.hrdata, 32'd0);
        chk({tag, " dmem_hready"}, 32'(dmem_if.hready), 32'd1);
        chk({tag, " ram_cs"},      32'(ram_cs), 32'd0);
        chk({tag, " ram_rwn"},     32'(ram_rwn), 32'd1);
        chk({tag, " ram_addr"},    32'(ram_addr), 32'd0);
        chk({tag, " ram_wdata"},   ram_wdata, 32'd0);
    endtask

    task automatic rand_master(input int m);
        int          kind, w, sub, gap;
        logic [31:0] a, d;
        logic        wr;
        logic [2:0]  sz;
        string       nm;
        nm = (m == 0) ? "rnd spi" : "rnd dmem";
        for (int i = 0; i < 25; i++) begin
            kind = $urandom_range(0, 9);
            w    = $urandom_range(0, 15);
            a    = ((m == 0) ? 32'h8000 : 32'h9000) + 32'(w) * 4;
            d    = $urandom;
            sz   = HSIZE_WORD;
            wr   = 1'b0;
            if (kind < 2) begin
                sub = $urandom_range(0, 2);
                wr  = 1'($urandom_range(0, 1));
                if (sub == 0)      sz = 3'b001;
                else if (sub == 1) a  = a + 32'd2;
                else               a  = 32'h0001_0000 + 32'(w) * 4;
                set_q(m, 0, a, wr, sz, d);
                run_master(m, 1);
                chk({nm, " err resp"}, 32'(res_resp[m][0]), 32'd1);
                chk_rng({nm, " err lat"}, res_done[m][0] - res_acc[m][0], 2, 2);
            end else if (kind < 6 || !valid[m][w]) begin
                set_q(m, 0, a, 1'b1, sz, d);
                run_master(m, 1);
                chk({nm, " wr resp"}, 32'(res_resp[m][0]), 32'd0);
                chk_rng({nm, " wr lat"}, res_done[m][0] - res_acc[m][0], 1, 2);
                model[m][w] = d;
                valid[m][w] = 1'b1;
            end else begin
                set_q(m, 0, a, 1'b0, sz, d);
                run_master(m, 1);
                chk({nm, " rd resp"}, 32'(res_resp[m][0]), 32'd0);
                chk_rng({nm, " rd lat"}, res_done[m][0] - res_acc[m][0], 2, 3);
                chk({nm, " rd data"}, res_rd[m][0], model[m][w]);
            end
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   base;
        int   a0;
        logic [31:0] exp_tie [4];

        tbl[0]  = '{0, 32'h0000_0100, 1'b1, 3'b010, 32'hDEADBEEF, 32'h0,        1'b0, 1, 1, 32'h040};
        tbl[1]  = '{1, 32'h0000_0100, 1'b0, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 32'h040};
        tbl[2]  = '{1, 32'h0001_0000, 1'b0, 3'b010, 32'h0,        32'h0,        1'b1, 2, 0, 32'h0};
        tbl[3]  = '{0, 32'h0000_0200, 1'b1, 3'b000, 32'h55AA55AA, 32'h0,        1'b1, 2, 0, 32'h0};
        tbl[4]  = '{1, 32'h0000_0102, 1'b0, 3'b010, 32'h0,        32'h0,        1'b1, 2, 0, 32'h0};
        tbl[5]  = '{0, 32'h0000_FFFC, 1'b1, 3'b010, 32'h12345678, 32'h0,        1'b0, 1, 1, 32'h3FFF};
        tbl[6]  = '{0, 32'h0000_FFFC, 1'b0, 3'b010, 32'h0,        32'h12345678, 1'b0, 2, 1, 32'h3FFF};
        tbl[7]  = '{1, 32'h0000_0000, 1'b1, 3'b010, 32'hA5A55A5A, 32'h0,        1'b0, 1, 1, 32'h0};
        tbl[8]  = '{1, 32'h0000_0004, 1'b1, 3'b010, 32'h11110004, 32'h0,        1'b0, 1, 1, 32'h1};
        tbl[9]  = '{1, 32'h0000_0008, 1'b1, 3'b010, 32'h22220008, 32'h0,        1'b0, 1, 1, 32'h2};
        tbl[10] = '{0, 32'hFFFF_FFFC, 1'b0, 3'b010, 32'h0,        32'h0,        1'b1, 2, 0, 32'h0};

        drive_addr(0, 32'h0, HTRANS_IDLE, 1'b0, HSIZE_WORD);
        drive_addr(1, 32'h0, HTRANS_IDLE, 1'b0, HSIZE_WORD);
        drive_wdata(0, 32'h0);
        drive_wdata(1, 32'h0);

        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("post-reset");

        // Single uncontended transfers from the table
        for (int i = 0; i < 11; i++) begin
            v    = tbl[i];
            base = log_n;
            set_q(v.m, 0, v.addr, v.wr, v.size, v.wd);
            run_master(v.m, 1);
            chk($sformatf("t%0d resp", i),   32'(res_resp[v.m][0]), 32'(v.resp));
            chk($sformatf("t%0d fresp", i),  32'(res_fresp[v.m][0]), 32'(v.resp));
            chk($sformatf("t%0d lat", i),    32'(res_done[v.m][0] - res_acc[v.m][0]), 32'(v.lat));
            chk($sformatf("t%0d rdata", i),  res_rd[v.m][0], v.rd);
            chk($sformatf("t%0d ram_cs n", i), 32'(log_n - base), 32'(v.ncs));
            if (log_n > base) begin
                chk($sformatf("t%0d ram_addr", i), log_addr[base], v.raddr);
                chk($sformatf("t%0d ram_rwn", i),  32'(log_rwn[base]), 32'(!v.wr));
                if (v.wr) chk($sformatf("t%0d ram_wdata", i), log_wd[base], v.wd);
            end
        end

        // Pipelined dmem reads of 0x0, 0x4, 0x8
        base = log_n;
        set_q(1, 0, 32'h0, 1'b0, HSIZE_WORD, 32'h0);
        set_q(1, 1, 32'h4, 1'b0, HSIZE_WORD, 32'h0);
        set_q(1, 2, 32'h8, 1'b0, HSIZE_WORD, 32'h0);
        run_master(1, 3);
        chk("pipe rd0", res_rd[1][0], 32'hA5A55A5A);
        chk("pipe rd1", res_rd[1][1], 32'h11110004);
        chk("pipe rd2", res_rd[1][2], 32'h22220008);
        chk("pipe ram n", 32'(log_n - base), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("pipe lat%0d", k), 32'(res_done[1][k] - res_acc[1][k]), 32'd2);
            chk($sformatf("pipe addr%0d", k), log_addr[base+k], 32'(k));
            chk($sformatf("pipe rwn%0d", k), 32'(log_rwn[base+k]), 32'd1);
            chk($sformatf("pipe cyc%0d", k), 32'(log_cyc[base+k] - res_acc[1][0]), 32'(2*k));
            if (k < 2) chk($sformatf("pipe overlap%0d", k), 32'(res_acc[1][k+1]), 32'(res_done[1][k]));
        end

        // Two back-to-back ties of pipelined writes
`ifdef DRAM_ARB_FIXED_PRIO_EN
        exp_tie = '{32'h0C0, 32'h0C1, 32'h100, 32'h101};
`else
        exp_tie = '{32'h0C0, 32'h100, 32'h0C1, 32'h101};
`endif
        base = log_n;
        set_q(0, 0, 32'h300, 1'b1, HSIZE_WORD, 32'h5A000300);
        set_q(0, 1, 32'h304, 1'b1, HSIZE_WORD, 32'h5A000304);
        set_q(1, 0, 32'h400, 1'b1, HSIZE_WORD, 32'hD0000400);
        set_q(1, 1, 32'h404, 1'b1, HSIZE_WORD, 32'hD0000404);
        fork
            run_master(0, 2);
            run_master(1, 2);
        join
        a0 = res_acc[0][0];
        chk("tie same accept", 32'(res_acc[1][0]), 32'(a0));
        chk("tie ram n", 32'(log_n - base), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tie addr%0d", k), log_addr[base+k], exp_tie[k]);
            chk($sformatf("tie cyc%0d", k), 32'(log_cyc[base+k] - a0), 32'(k));
        end
        chk("tie spi lat0", 32'(res_done[0][0] - res_acc[0][0]), 32'd1);

        // Reset asserted while an SPI read is in its read-data cycle
        set_q(0, 0, 32'h100, 1'b0, HSIZE_WORD, 32'h0);
        drive_addr(0, 32'h100, HTRANS_NONSEQ, 1'b0, HSIZE_WORD);
        @(posedge clk); #1;
        drive_addr(0, 32'h0, HTRANS_IDLE, 1'b0, HSIZE_WORD);
        chk("rst-rd wait hready", 32'(spi_if.hready), 32'd0);
        chk("rst-rd wait cs", 32'(ram_cs), 32'd1);
        @(posedge clk); #1;
        chk("rst-rd rdata", spi_if.hrdata, 32'hDEADBEEF);
        rst_n = 1'b0;
        #1 chk_reset_outputs("mid-read reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        base = log_n;
        set_q(0, 0, 32'h500, 1'b1, HSIZE_WORD, 32'h00000500);
        set_q(1, 0, 32'h600, 1'b1, HSIZE_WORD, 32'h00000600);
        fork
            run_master(0, 1);
            run_master(1, 1);
        join
        chk("post-reset tie n", 32'(log_n - base), 32'd2);
        chk("post-reset tie first", log_addr[base], 32'h140);
        chk("post-reset dmem lat", 32'(res_done[1][0] - res_acc[1][0]), 32'd2);

        // Concurrent random traffic in disjoint per-master regions
        fork
            rand_master(0);
            rand_master(1);
        join

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Two-master AHB-lite slave that shares the single-port data RAM between the SPI loader and the RISC-V core data port (dmem).
- Sits between the two AHB-lite master ports and the data RAM.
- Captures each master's address phase, arbitrates RAM cycles, and inserts wait states for the losing master.
- Checks address range and transfer size, and returns the two-cycle AHB ERROR response on violations.

Parameters:
- RAM_AW, 14, RAM word-address width; RAM byte span = 2^(RAM_AW+2).
- BASE_ADDR, 32'h0000_0000, byte base of RAM window; must be aligned to the span.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- spi_haddr  in  32  SPI address-phase address.
- spi_htrans  in  2  SPI transfer type; bit1=1 means NONSEQ/SEQ (valid).
- spi_hwrite  in  1  SPI write (1) / read (0).
- spi_hsize  in  3  SPI size; only 3'b010 (word) is legal.
- spi_hwdata  in  32  SPI write data, valid in the data phase.
- spi_hready  out  1  SPI transfer done / slave ready.
- spi_hresp  out  1  SPI response; 0 = OKAY, 1 = ERROR.
- spi_hrdata  out  32  SPI read data.
- dmem_haddr, dmem_htrans, dmem_hwrite, dmem_hsize, dmem_hwdata, dmem_hready, dmem_hresp, dmem_hrdata: same widths and meanings, for the core data port.
- ram_cs  out  1  RAM access strobe.
- ram_rwn  out  1  1 = read, 0 = write.
- ram_addr  out  RAM_AW  RAM word address = haddr[RAM_AW+1:2].
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  synchronous RAM read data, valid the cycle after a read strobe.

Behaviour:
- Reset (async assert, sync release): both ports go to P_IDLE; last_grant = DMEM; pending registers are cleared.
  - Outputs during and after reset: hready=1, hresp=0, hrdata=0, ram_cs=0, ram_rwn=1, ram_addr=0, ram_wdata=0.
- Acceptance: at each rising edge where a port's hready=1 and htrans[1]=1, latch haddr/hwrite/hsize into that port's pending register. Address-phase inputs are ignored at any other edge.
- Error check at acceptance: an error is flagged when hsize!=3'b010, haddr[1:0]!=0, or haddr lies outside [BASE_ADDR, BASE_ADDR+span).
- Per-port state machine; "next" means: accepted error -> P_ERR1; accepted OK -> P_WAIT; nothing accepted -> P_IDLE.
  - P_IDLE: hready=1, hresp=0. Takes next at each edge.
  - P_WAIT: hready=0, unless this port is granted and the transfer is a write.
    - Granted write: ram_cs=1, rwn=0, wdata=port hwdata, hready=1 (zero wait states); then next.
    - Granted read: ram_cs=1, rwn=1, hready=0; go to P_RDATA.
    - Not granted: stay in P_WAIT.
  - P_RDATA: hready=1, hrdata=ram_rdata; then next. The RAM is free this cycle for the other port.
  - P_ERR1: hready=0, hresp=1; go to P_ERR2.
  - P_ERR2: hready=1, hresp=1; then next. A master driving IDLE here is honoured.
- hrdata = 0 outside P_RDATA. ram_cs = 0 when nothing is granted; ram_addr and ram_wdata then hold their last values.
- Arbitration (combinational from registered state):
  - Only ports in P_WAIT request; if one requests, it is granted.
  - Tie: grant the port != last_grant. last_grant updates on every grant.
- Latency: uncontended write has a 1-cycle data phase; uncontended read has 2 cycles (1 wait state). A tie adds 1 cycle to the loser.
- hburst, hprot and hmastlock are not ports; all transfers are treated as single.

Optional Feature:
- Macro: DRAM_ARB_FIXED_PRIO_EN.
- Defined: SPI always wins ties; last_grant is removed.
- Undefined: round-robin arbitration as specified above.

Decomposition:
- Package dram_arb_pkg: port-state enum (P_IDLE, P_WAIT, P_RDATA, P_ERR1, P_ERR2), HTRANS_IDLE/NONSEQ/SEQ, HSIZE_WORD, HRESP_OKAY/ERROR, and MST_SPI/MST_DMEM ids.
- Sub-module ahb_port_ctrl, instantiated twice: pending register, state machine, error check, and hready/hresp/hrdata generation.
- Arbitration and the RAM output mux live in the top module.

Test Plan:
- SPI write 0x100 <- 0xDEADBEEF, dmem idle -> data-phase cycle: ram_cs=1, rwn=0, ram_addr=0x040, ram_wdata=0xDEADBEEF, spi_hready=1.
- dmem read 0x100 after the above -> cycle 1: ram_cs=1, rwn=1, dmem_hready=0; cycle 2: dmem_hready=1, dmem_hrdata=0xDEADBEEF.
- SPI and dmem both write in the same cycle, twice in a row -> first tie: SPI granted, dmem_hready=0 for 1 cycle; second tie: dmem granted first (round-robin; SPI first again with DRAM_ARB_FIXED_PRIO_EN).
- dmem read of 0x0001_0000, and a separate SPI hsize=3'b000 access -> hready=0/hresp=1 then hready=1/hresp=1; ram_cs stays 0 throughout.
- Pipelined dmem reads of 0x0, 0x4, 0x8 -> second address accepted on the edge where the first completes; each read has exactly 1 wait state; ram_addr sequence 0, 1, 2.
- reset driven low mid-read (P_RDATA) -> immediately hready=1, hresp=0, ram_cs=0; after release, a first tie goes to SPI.
